// File: rtl/game_collision_ctrl.sv
// Collision, score, lives and game-state controller for the car game.
// Consumes car/obstacle positions and drives reset_game plus the renderer status outputs.
module game_collision_ctrl #(
  parameter int CAR_W       = 40,
  parameter int CAR_H       = 60,
  parameter int OBS_W       = 50,
  parameter int OBS_H       = 40,
  parameter int LIVES_INI   = 3,
  parameter int HIT_TICKS   = 25_000_000,
  parameter int BLINK_TICKS = 3_125_000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST,
  input  logic        start,
  input  logic [9:0]  car_h_pos,
  input  logic [8:0]  car_v_pos,
  input  logic [9:0]  obs1_h_pos,
  input  logic [8:0]  obs1_v_pos,
  input  logic [9:0]  obs2_h_pos,
  input  logic [8:0]  obs2_v_pos,
  output logic        reset_game,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic        game_over,
  output logic        car_visible,
  output logic        hit_pulse
);

  localparam int TW = $clog2(HIT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [13:0] SCORE_MAX = 14'd16383;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  // All four edge tests widened to 11 bits so right/bottom edges never wrap.
  function automatic logic overlap(input logic [9:0] ch, input logic [8:0] cv,
                                   input logic [9:0] oh, input logic [8:0] ov);
    logic [10:0] ch_e, cv_e, oh_e, ov_e;
    ch_e = {1'b0, ch};
    cv_e = {2'b00, cv};
    oh_e = {1'b0, oh};
    ov_e = {2'b00, ov};
    overlap = (ch_e < oh_e + 11'(OBS_W)) && (oh_e < ch_e + 11'(CAR_W)) &&
              (cv_e < ov_e + 11'(OBS_H)) && (ov_e < cv_e + 11'(CAR_H));
  endfunction

  state_t        state_r;
  logic          hit1_r, hit2_r;
  logic [8:0]    prev_v1_r, prev_v2_r;
  logic [TW-1:0] timer_r;
  logic [BW-1:0] blink_r;
  logic          wrap1_s, wrap2_s;
  logic [14:0]   score_sum_s;
  logic [13:0]   score_next_s;

  // Wrap detection and saturating score increment
  always_comb begin
    wrap1_s     = (obs1_v_pos < prev_v1_r);
    wrap2_s     = (obs2_v_pos < prev_v2_r);
    score_sum_s = {1'b0, score} + 15'(wrap1_s) + 15'(wrap2_s);
    if (score_sum_s > {1'b0, SCORE_MAX}) begin
      score_next_s = SCORE_MAX;
    end else begin
      score_next_s = score_sum_s[13:0];
    end
  end

  // Stage 1: registered overlap flags and previous obstacle rows
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      hit1_r    <= 1'b0;
      hit2_r    <= 1'b0;
      prev_v1_r <= 9'd0;
      prev_v2_r <= 9'd0;
    end else begin
      hit1_r    <= overlap(car_h_pos, car_v_pos, obs1_h_pos, obs1_v_pos);
      hit2_r    <= overlap(car_h_pos, car_v_pos, obs2_h_pos, obs2_v_pos);
      prev_v1_r <= obs1_v_pos;
      prev_v2_r <= obs2_v_pos;
    end
  end

  // Game FSM with registered outputs
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_r     <= ST_IDLE;
      reset_game  <= 1'b1;
      lives       <= 2'd0;
      score       <= 14'd0;
      game_over   <= 1'b0;
      car_visible <= 1'b1;
      hit_pulse   <= 1'b0;
      timer_r     <= '0;
      blink_r     <= '0;
    end else begin
      hit_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          reset_game <= 1'b1;
          if (start) begin
            state_r    <= ST_PLAYING;
            lives      <= 2'(LIVES_INI);
            score      <= 14'd0;
            reset_game <= 1'b0;
          end
        end
        ST_PLAYING: begin
          score <= score_next_s;
          if (hit1_r || hit2_r) begin
            lives     <= lives - 2'd1;
            hit_pulse <= 1'b1;
            timer_r   <= '0;
            blink_r   <= '0;
            if (lives == 2'd1) begin
              state_r    <= ST_GAME_OVER;
              game_over  <= 1'b1;
              reset_game <= 1'b1;
            end else begin
              state_r     <= ST_HIT;
              car_visible <= 1'b0;
            end
          end
        end
        ST_HIT: begin
          score <= score_next_s;
          if (timer_r == TW'(HIT_TICKS - 1)) begin
            state_r     <= ST_PLAYING;
            car_visible <= 1'b1;
            timer_r     <= '0;
            blink_r     <= '0;
          end else begin
            timer_r <= timer_r + TW'(1);
            if (blink_r == BW'(BLINK_TICKS - 1)) begin
              blink_r     <= '0;
              car_visible <= ~car_visible;
            end else begin
              blink_r <= blink_r + BW'(1);
            end
          end
        end
        ST_GAME_OVER: begin
          game_over  <= 1'b1;
          reset_game <= 1'b1;
          if (start) begin
            state_r    <= ST_PLAYING;
            lives      <= 2'(LIVES_INI);
            score      <= 14'd0;
            game_over  <= 1'b0;
            reset_game <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_collision_ctrl.sv
// Self-checking bench for game_collision_ctrl: directed scenarios, score saturation
// and randomized play, compared every cycle against a behavioural game model.
module tb_game_collision_ctrl;

  localparam int HIT_T   = 100;
  localparam int BLINK_T = 10;
  localparam int LIVES0  = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  car_h, o1h, o2h;
  logic [8:0]  car_v, o1v, o2v;
  logic        reset_game, game_over, car_visible, hit_pulse;
  logic [1:0]  lives;
  logic [13:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  game_collision_ctrl #(
    .CAR_W(40), .CAR_H(60), .OBS_W(50), .OBS_H(40), .LIVES_INI(LIVES0),
    .HIT_TICKS(HIT_T), .BLINK_TICKS(BLINK_T)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst), .start(start),
    .car_h_pos(car_h), .car_v_pos(car_v),
    .obs1_h_pos(o1h), .obs1_v_pos(o1v),
    .obs2_h_pos(o2h), .obs2_v_pos(o2v),
    .reset_game(reset_game), .lives(lives), .score(score),
    .game_over(game_over), .car_visible(car_visible), .hit_pulse(hit_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit boxes_overlap(input int ch, input int cv, input int oh, input int ov);
    return (ch < oh + 50) && (oh < ch + 40) && (cv < ov + 40) && (ov < cv + 60);
  endfunction

  // Behavioural model: mode 0 idle, 1 playing, 2 invulnerable, 3 over
  int m_mode = 0, m_lives = 0, m_score = 0, m_elapsed = 0;
  bit m_pulse = 0, m_hit = 0;
  int m_p1 = 0, m_p2 = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_mode = 0; m_lives = 0; m_score = 0; m_elapsed = 0;
        m_pulse = 0; m_hit = 0; m_p1 = 0; m_p2 = 0;
      end else begin
        int gained;
        gained  = (int'(o1v) < m_p1 ? 1 : 0) + (int'(o2v) < m_p2 ? 1 : 0);
        m_pulse = 0;
        if (m_mode == 1 || m_mode == 2) begin
          m_score = (m_score + gained > 16383) ? 16383 : m_score + gained;
        end
        if (m_mode == 0 || m_mode == 3) begin
          if (start) begin
            m_mode = 1; m_lives = LIVES0; m_score = 0;
          end
        end else if (m_mode == 1) begin
          if (m_hit) begin
            m_pulse   = 1;
            m_elapsed = 0;
            m_mode    = (m_lives == 1) ? 3 : 2;
            m_lives   = m_lives - 1;
          end
        end else begin
          if (m_elapsed == HIT_T - 1) m_mode = 1;
          else m_elapsed++;
        end
        m_hit = boxes_overlap(car_h, car_v, o1h, o1v) || boxes_overlap(car_h, car_v, o2h, o2v);
        m_p1  = int'(o1v);
        m_p2  = int'(o2v);
      end
      chk("reset_game", 32'(reset_game), (m_mode == 0 || m_mode == 3) ? 1 : 0);
      chk("game_over", 32'(game_over), (m_mode == 3) ? 1 : 0);
      chk("lives", 32'(lives), m_lives);
      chk("score", 32'(score), m_score);
      chk("hit_pulse", 32'(hit_pulse), m_pulse ? 1 : 0);
      if (m_mode != 3)
        chk("car_visible", 32'(car_visible), (m_mode == 2) ? ((m_elapsed / BLINK_T) % 2) : 1);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int toggles;
    logic vis_prev;
    int rv1, rv2, rh1, rh2;
    rst = 1'b1; start = 1'b0;
    car_h = 10'd300; car_v = 9'd400;
    o1h = 10'd120; o1v = 9'd0; o2h = 10'd320; o2v = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_reset_game", 32'(reset_game), 1);
    chk("rst_lives", 32'(lives), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_visible", 32'(car_visible), 1);
    chk("rst_pulse", 32'(hit_pulse), 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    chk("start_reset_game", 32'(reset_game), 0);
    chk("start_lives", 32'(lives), 3);
    chk("start_score", 32'(score), 0);
    chk("start_pulse", 32'(hit_pulse), 0);

    for (int i = 1; i <= 10; i++) begin
      o1v = 9'(i * 10);
      @(negedge clk);
    end
    o1v = 9'd0;
    @(negedge clk);
    chk("single_wrap", 32'(score), 1);
    o1v = 9'd100; o2v = 9'd100;
    @(negedge clk);
    o1v = 9'd0; o2v = 9'd0;
    @(negedge clk);
    chk("double_wrap", 32'(score), 3);

    // Obstacle bottom exactly on the car top: no hit
    o2v = 9'd360;
    repeat (4) @(negedge clk);
    chk("edge_touch_lives", 32'(lives), 3);
    o2v = 9'd361;
    @(negedge clk);
    chk("pulse_latency1", 32'(hit_pulse), 0);
    o2h = 10'd500;
    vis_prev = car_visible;
    toggles = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("hit_pulse_at2", 32'(hit_pulse), 1);
        chk("hit_lives", 32'(lives), 2);
      end
      if (car_visible !== vis_prev) toggles++;
      vis_prev = car_visible;
    end
    chk("blink_toggles", 32'(toggles), 10);
    chk("visible_after_hit", 32'(car_visible), 1);

    for (int k = 0; k < 2; k++) begin
      o2h = 10'd320;
      @(negedge clk);
      o2h = 10'd500;
      @(negedge clk);
      chk("repeat_hit_pulse", 32'(hit_pulse), 1);
      chk("repeat_hit_lives", 32'(lives), (k == 0) ? 1 : 0);
      if (k == 0) repeat (105) @(negedge clk);
    end
    chk("go_game_over", 32'(game_over), 1);
    chk("go_reset_game", 32'(reset_game), 1);
    o1v = 9'd100;
    @(negedge clk);
    o1v = 9'd0;
    repeat (2) @(negedge clk);
    chk("go_score_frozen", 32'(score), 3);
    pulse_start();
    chk("restart_lives", 32'(lives), 3);
    chk("restart_score", 32'(score), 0);
    chk("restart_game_over", 32'(game_over), 0);
    chk("restart_reset_game", 32'(reset_game), 0);

    for (int i = 0; i < 5; i++) begin
      o1v = 9'd100;
      @(negedge clk);
      o1v = 9'd0;
      @(negedge clk);
    end
    chk("score_five", 32'(score), 5);
    o2h = 10'd320;
    @(negedge clk);
    o2h = 10'd500;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midhit_rst_score", 32'(score), 0);
    chk("midhit_rst_visible", 32'(car_visible), 1);
    chk("midhit_rst_reset_game", 32'(reset_game), 1);
    chk("midhit_rst_lives", 32'(lives), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();

    // One obstacle wraps every cycle, driving the score into saturation
    for (int i = 0; i < 16500; i++) begin
      o1v = (i % 2 == 1) ? 9'd0 : 9'd1;
      o2v = (i % 2 == 1) ? 9'd1 : 9'd0;
      @(negedge clk);
    end
    chk("score_saturated", 32'(score), 16383);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv1 = 0; rv2 = 200; rh1 = 300; rh2 = 250;
    for (int i = 0; i < 5000; i++) begin
      if (rst) rst = 1'b0;
      else rst = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 79) == 0);
      rv1 = rv1 + int'($urandom_range(0, 12));
      if (rv1 > 479) begin
        rv1 = int'($urandom_range(0, 15));
        rh1 = int'($urandom_range(200, 420));
      end
      rv2 = rv2 + int'($urandom_range(0, 12));
      if (rv2 > 479) begin
        rv2 = int'($urandom_range(0, 15));
        rh2 = int'($urandom_range(200, 420));
      end
      o1v = 9'(rv1); o1h = 10'(rh1);
      o2v = 9'(rv2); o2h = 10'(rh2);
      if ($urandom_range(0, 15) == 0) begin
        car_h = 10'($urandom_range(250, 350));
        car_v = 9'($urandom_range(380, 419));
      end
      @(negedge clk);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
